// File: rtl/smvm_scheduler.sv
// smvm_scheduler: packs a stream of COO nonzeros into LANES-wide beats for the
// sparse-matrix/vector multiplier and sequences one matrix pass
// (IDLE -> FILL -> DRAIN -> FIN).
// Optional feature: define SMVM_ROW_CHECK_EN to drop nonzeros whose row index
// falls outside the accumulator (in_row >= NUM_ROWS) and flag them on err_row.
module smvm_scheduler #(
    parameter int LANES    = 4,
    parameter int NUM_ROWS = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_value,
    input  logic [31:0]            in_row,
    input  logic [31:0]            in_col,
    input  logic                   in_last,
    output logic [LANES-1:0][31:0] values,
    output logic [LANES-1:0][31:0] row_id,
    output logic [LANES-1:0][31:0] col_id,
    output logic                   rdy,
    input  logic                   mult_done,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            nnz_count,
    output logic [31:0]            beat_count,
    output logic                   err_row
);

    localparam int DATA_W = 32;
    localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t state;

    // Staging register: lanes collected so far for the beat under construction.
    logic [LANES-1:0][DATA_W-1:0] stage_val_p0;
    logic [LANES-1:0][DATA_W-1:0] stage_row_p0;
    logic [LANES-1:0][DATA_W-1:0] stage_col_p0;
    logic [IDX_W-1:0]             lane_idx_p0;

    // Staging contents with the nonzero accepted this cycle merged in.
    logic [LANES-1:0][DATA_W-1:0] merge_val;
    logic [LANES-1:0][DATA_W-1:0] merge_row;
    logic [LANES-1:0][DATA_W-1:0] merge_col;

    logic hs;
    logic row_ok;
    logic place;
    logic issue;

`ifdef SMVM_ROW_CHECK_EN
    function automatic logic row_in_range(input logic [DATA_W-1:0] r);
        return (r < DATA_W'(NUM_ROWS));
    endfunction
`endif

    // Handshake qualification and the decision to emit a beat this cycle.
    always_comb begin
        hs = in_valid & in_ready;
`ifdef SMVM_ROW_CHECK_EN
        row_ok = row_in_range(in_row);
`else
        row_ok = 1'b1;
`endif
        place = hs & row_ok;
        // A full lane set or the last nonzero closes the beat; a rejected last
        // nonzero still flushes whatever is already staged.
        issue = (place && ((lane_idx_p0 == LAST_LANE) || in_last)) ||
                (hs && !row_ok && in_last && (lane_idx_p0 != '0));
    end

    // Merge the incoming nonzero into its lane; untouched lanes keep staged (or zero) data.
    always_comb begin
        merge_val = stage_val_p0;
        merge_row = stage_row_p0;
        merge_col = stage_col_p0;
        if (place) begin
            merge_val[lane_idx_p0] = in_value;
            merge_row[lane_idx_p0] = in_row;
            merge_col[lane_idx_p0] = in_col;
        end
    end

    // Pass-control FSM with registered outputs, staging, beat output and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rdy          <= 1'b0;
            nnz_count    <= '0;
            beat_count   <= '0;
            values       <= '0;
            row_id       <= '0;
            col_id       <= '0;
            stage_val_p0 <= '0;
            stage_row_p0 <= '0;
            stage_col_p0 <= '0;
            lane_idx_p0  <= '0;
`ifdef SMVM_ROW_CHECK_EN
            err_row      <= 1'b0;
`endif
        end else begin
            rdy  <= 1'b0;
            done <= 1'b0;
            if (abort) begin
                // Cancel: drop the partial beat, keep counters and err_row for inspection.
                state        <= IDLE;
                in_ready     <= 1'b0;
                busy         <= 1'b0;
                stage_val_p0 <= '0;
                stage_row_p0 <= '0;
                stage_col_p0 <= '0;
                lane_idx_p0  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state        <= FILL;
                            in_ready     <= 1'b1;
                            busy         <= 1'b1;
                            nnz_count    <= '0;
                            beat_count   <= '0;
                            stage_val_p0 <= '0;
                            stage_row_p0 <= '0;
                            stage_col_p0 <= '0;
                            lane_idx_p0  <= '0;
`ifdef SMVM_ROW_CHECK_EN
                            err_row      <= 1'b0;
`endif
                        end
                    end
                    FILL: begin
                        if (place) begin
                            nnz_count <= nnz_count + 32'd1;
                        end
                        if (issue) begin
                            values       <= merge_val;
                            row_id       <= merge_row;
                            col_id       <= merge_col;
                            rdy          <= 1'b1;
                            beat_count   <= beat_count + 32'd1;
                            stage_val_p0 <= '0;
                            stage_row_p0 <= '0;
                            stage_col_p0 <= '0;
                            lane_idx_p0  <= '0;
                        end else if (place) begin
                            stage_val_p0 <= merge_val;
                            stage_row_p0 <= merge_row;
                            stage_col_p0 <= merge_col;
                            lane_idx_p0  <= lane_idx_p0 + 1'b1;
                        end
`ifdef SMVM_ROW_CHECK_EN
                        if (hs && !row_ok) begin
                            err_row <= 1'b1;
                        end
`endif
                        if (hs && in_last) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                    DRAIN: begin
                        // The multiplier cannot have finished the final beat while it is still on the bus.
                        if (mult_done && !rdy) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifndef SMVM_ROW_CHECK_EN
    assign err_row = 1'b0;
`endif

endmodule

// File: tb/tb_smvm_scheduler.sv
// Directed, table-driven bench for smvm_scheduler (LANES=4, NUM_ROWS=128).
module tb_smvm_scheduler;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_value;
    logic [31:0]      in_row;
    logic [31:0]      in_col;
    logic             in_last;
    logic [3:0][31:0] values;
    logic [3:0][31:0] row_id;
    logic [3:0][31:0] col_id;
    logic             rdy;
    logic             mult_done;
    logic             busy;
    logic             done;
    logic [31:0]      nnz_count;
    logic [31:0]      beat_count;
    logic             err_row;

    int errors = 0;
    int checks = 0;

    smvm_scheduler #(.LANES(4), .NUM_ROWS(128)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .in_row(in_row), .in_col(in_col), .in_last(in_last),
        .values(values), .row_id(row_id), .col_id(col_id), .rdy(rdy),
        .mult_done(mult_done), .busy(busy), .done(done),
        .nnz_count(nnz_count), .beat_count(beat_count), .err_row(err_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           st;
        bit           vld;
        bit           md;
        int unsigned  val;
        int unsigned  row;
        int unsigned  col;
        bit           last;
        bit           e_rdy;
        bit           e_busy;
        bit           e_inr;
        bit           e_done;
        int unsigned  e_nnz;
        int unsigned  e_beat;
        logic [127:0] e_vals;
        logic [127:0] e_rows;
        logic [127:0] e_cols;
    } vec_t;

    vec_t vecs[22];

    function automatic logic [127:0] p4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
        return {d, c, b, a};
    endfunction

    function automatic vec_t mk(input bit st, input bit vld, input bit md,
                                input int unsigned val, input int unsigned row,
                                input int unsigned col, input bit last,
                                input bit e_rdy, input bit e_busy, input bit e_inr,
                                input bit e_done, input int unsigned e_nnz,
                                input int unsigned e_beat, input logic [127:0] ev,
                                input logic [127:0] er, input logic [127:0] ec);
        vec_t v;
        v.st = st; v.vld = vld; v.md = md;
        v.val = val; v.row = row; v.col = col; v.last = last;
        v.e_rdy = e_rdy; v.e_busy = e_busy; v.e_inr = e_inr; v.e_done = e_done;
        v.e_nnz = e_nnz; v.e_beat = e_beat;
        v.e_vals = ev; v.e_rows = er; v.e_cols = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_nz(input int unsigned v, input int unsigned r,
                           input int unsigned c, input bit last);
        in_valid = 1'b1;
        in_value = v;
        in_row   = r;
        in_col   = c;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Finish a pass sitting in DRAIN: one cycle clear of the beat, then mult_done.
    task automatic finish_pass();
        tick();
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] Z;
        logic [127:0] va1, ca1, va2, ca2, vb1, rb1, cb1, vb2, rb2, cb2;
        int bad;

        Z   = '0;
        va1 = p4(1, 2, 3, 4);       ca1 = p4(101, 102, 103, 104);
        va2 = p4(5, 6, 7, 8);       ca2 = p4(105, 106, 107, 108);
        vb1 = p4(11, 12, 13, 14);   rb1 = p4(20, 21, 22, 23);   cb1 = p4(120, 121, 122, 123);
        vb2 = p4(15, 0, 0, 0);      rb2 = p4(24, 0, 0, 0);      cb2 = p4(124, 0, 0, 0);

        // Pass A: 8 nonzeros, one idle gap, start ignored mid-pass, mult_done during rdy ignored.
        vecs[0]  = mk(1,0,0, 0,0,0,0,     0,1,1,0, 0,0, Z,Z,Z);
        vecs[1]  = mk(0,1,0, 1,1,101,0,   0,1,1,0, 1,0, Z,Z,Z);
        vecs[2]  = mk(0,1,0, 2,2,102,0,   0,1,1,0, 2,0, Z,Z,Z);
        vecs[3]  = mk(0,0,0, 0,0,0,0,     0,1,1,0, 2,0, Z,Z,Z);
        vecs[4]  = mk(1,1,0, 3,3,103,0,   0,1,1,0, 3,0, Z,Z,Z);
        vecs[5]  = mk(0,1,0, 4,4,104,0,   1,1,1,0, 4,1, va1,va1,ca1);
        vecs[6]  = mk(0,1,0, 5,5,105,0,   0,1,1,0, 5,1, va1,va1,ca1);
        vecs[7]  = mk(0,1,0, 6,6,106,0,   0,1,1,0, 6,1, va1,va1,ca1);
        vecs[8]  = mk(0,1,0, 7,7,107,0,   0,1,1,0, 7,1, va1,va1,ca1);
        vecs[9]  = mk(0,1,0, 8,8,108,1,   1,1,0,0, 8,2, va2,va2,ca2);
        vecs[10] = mk(0,0,1, 0,0,0,0,     0,1,0,0, 8,2, va2,va2,ca2);
        vecs[11] = mk(0,0,1, 0,0,0,0,     0,1,0,1, 8,2, va2,va2,ca2);
        vecs[12] = mk(0,0,0, 0,0,0,0,     0,0,0,0, 8,2, va2,va2,ca2);
        // Pass B: 5 nonzeros, partial second beat.
        vecs[13] = mk(1,0,0, 0,0,0,0,     0,1,1,0, 0,0, va2,va2,ca2);
        vecs[14] = mk(0,1,0, 11,20,120,0, 0,1,1,0, 1,0, va2,va2,ca2);
        vecs[15] = mk(0,1,0, 12,21,121,0, 0,1,1,0, 2,0, va2,va2,ca2);
        vecs[16] = mk(0,1,0, 13,22,122,0, 0,1,1,0, 3,0, va2,va2,ca2);
        vecs[17] = mk(0,1,0, 14,23,123,0, 1,1,1,0, 4,1, vb1,rb1,cb1);
        vecs[18] = mk(0,1,0, 15,24,124,1, 1,1,0,0, 5,2, vb2,rb2,cb2);
        vecs[19] = mk(0,0,1, 0,0,0,0,     0,1,0,0, 5,2, vb2,rb2,cb2);
        vecs[20] = mk(0,0,1, 0,0,0,0,     0,1,0,1, 5,2, vb2,rb2,cb2);
        vecs[21] = mk(0,0,0, 0,0,0,0,     0,0,0,0, 5,2, vb2,rb2,cb2);

        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        in_value = '0; in_row = '0; in_col = '0; in_last = 1'b0; mult_done = 1'b0;
        tick();
        tick();
        check("rst.rdy", rdy, 0);
        check("rst.busy", busy, 0);
        check("rst.in_ready", in_ready, 0);
        check("rst.done", done, 0);
        check("rst.nnz", nnz_count, 0);
        check("rst.beats", beat_count, 0);
        check("rst.values", values, 0);
        check("rst.err_row", err_row, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 22; i++) begin
            start     = vecs[i].st;
            in_valid  = vecs[i].vld;
            mult_done = vecs[i].md;
            in_value  = vecs[i].val;
            in_row    = vecs[i].row;
            in_col    = vecs[i].col;
            in_last   = vecs[i].last;
            tick();
            check($sformatf("v%0d.rdy", i), rdy, vecs[i].e_rdy);
            check($sformatf("v%0d.busy", i), busy, vecs[i].e_busy);
            check($sformatf("v%0d.in_ready", i), in_ready, vecs[i].e_inr);
            check($sformatf("v%0d.done", i), done, vecs[i].e_done);
            check($sformatf("v%0d.nnz", i), nnz_count, vecs[i].e_nnz);
            check($sformatf("v%0d.beats", i), beat_count, vecs[i].e_beat);
            check($sformatf("v%0d.values", i), values, vecs[i].e_vals);
            check($sformatf("v%0d.row_id", i), row_id, vecs[i].e_rows);
            check($sformatf("v%0d.col_id", i), col_id, vecs[i].e_cols);
        end
        start = 1'b0; in_valid = 1'b0; mult_done = 1'b0; in_last = 1'b0;

        // mult_done arrives 10 cycles after the last beat.
        pulse_start();
        send_nz(31, 5, 131, 0);
        send_nz(32, 6, 132, 0);
        send_nz(33, 7, 133, 1);
        check("late.rdy", rdy, 1);
        check("late.values", values, p4(31, 32, 33, 0));
        check("late.nnz", nnz_count, 3);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b1 || rdy !== 1'b0) bad++;
        end
        check("late.wait_quiet", bad, 0);
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        check("late.done", done, 1);
        check("late.busy_in_done", busy, 1);
        tick();
        check("late.done_one_cycle", done, 0);
        check("late.busy_after", busy, 0);

        // Abort after two nonzeros, then a fresh pass.
        pulse_start();
        send_nz(41, 1, 1, 0);
        send_nz(42, 2, 2, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort.busy", busy, 0);
        check("abort.in_ready", in_ready, 0);
        check("abort.nnz", nnz_count, 2);
        check("abort.beats", beat_count, 0);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (rdy !== 1'b0) bad++;
            tick();
        end
        check("abort.no_rdy", bad, 0);
        check("abort.values_hold", values, p4(31, 32, 33, 0));
        pulse_start();
        check("restart.nnz", nnz_count, 0);
        check("restart.in_ready", in_ready, 1);
        send_nz(51, 3, 3, 0);
        send_nz(52, 4, 4, 1);
        check("restart.rdy", rdy, 1);
        check("restart.values", values, p4(51, 52, 0, 0));
        check("restart.beats", beat_count, 1);
        finish_pass();
        check("restart.idle", busy, 0);

        // Asynchronous reset in the middle of FILL.
        pulse_start();
        send_nz(61, 1, 1, 0);
        send_nz(62, 2, 2, 0);
        send_nz(63, 3, 3, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst.busy", busy, 0);
        check("arst.in_ready", in_ready, 0);
        check("arst.nnz", nnz_count, 0);
        check("arst.beats", beat_count, 0);
        check("arst.values", values, 0);
        check("arst.row_id", row_id, 0);
        check("arst.rdy", rdy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (rdy !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("arst.no_beat", bad, 0);
        pulse_start();
        send_nz(71, 9, 9, 1);
        check("arst.fresh_values", values, p4(71, 0, 0, 0));
        check("arst.fresh_beats", beat_count, 1);
        finish_pass();

        // Row indices at and beyond NUM_ROWS.
        pulse_start();
        send_nz(81, 127, 1, 0);
        send_nz(82, 128, 2, 0);
        send_nz(83, 128, 3, 0);
        send_nz(84, 128, 4, 1);
        check("row.rdy", rdy, 1);
        check("row.in_ready", in_ready, 0);
        check("row.beats", beat_count, 1);
`ifdef SMVM_ROW_CHECK_EN
        check("row.row_id", row_id, p4(127, 0, 0, 0));
        check("row.values", values, p4(81, 0, 0, 0));
        check("row.nnz", nnz_count, 1);
        check("row.err_row", err_row, 1);
`else
        check("row.row_id", row_id, p4(127, 128, 128, 128));
        check("row.values", values, p4(81, 82, 83, 84));
        check("row.nnz", nnz_count, 4);
        check("row.err_row", err_row, 0);
`endif
        finish_pass();
`ifdef SMVM_ROW_CHECK_EN
        check("row.err_sticky", err_row, 1);
        pulse_start();
        check("row.err_cleared", err_row, 0);
        send_nz(90, 200, 0, 1);
        check("row.empty_no_rdy", rdy, 0);
        check("row.empty_drain", in_ready, 0);
        check("row.empty_beats", beat_count, 0);
        check("row.empty_err", err_row, 1);
        finish_pass();
        check("row.empty_idle", busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
